uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side byte buffer and launcher that sits directly upstream of the UART transmitter. It accepts bytes from the MCU bus side into a DEPTH-entry FIFO. It then feeds them one at a time to the transmitter's start/byte/active/done handshake, so software can queue bursts without polling per byte. It also reports occupancy, a sticky overflow flag and a combined busy status for the UART status register.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256
- CW, $clog2(DEPTH)+1: width of o_Count (derived, not overridden)
- i_Clock  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_Wr_En  in  1  one-cycle write strobe from bus
- i_Wr_Byte  in  8  byte to enqueue, valid with i_Wr_En
- i_Tx_Enable  in  1  1 = launching of queued bytes allowed
- i_Clr_Ovf  in  1  clears o_Overflow
- o_Full  out  1  o_Count == DEPTH
- o_Empty  out  1  o_Count == 0
- o_Count  out  CW  bytes stored (excludes byte currently in transmitter)
- o_Overflow  out  1  sticky: a write was dropped
- o_Busy  out  1  FIFO non-empty or launcher not in L_IDLE
- o_Tx_DV  out  1  start pulse to transmitter (its i_Tx_DV)
- o_Tx_Byte  out  8  byte to transmitter (its i_Tx_Byte)
- i_Tx_Active  in  1  transmitter active flag (status only)
- i_Tx_Done  in  1  transmitter done flag

## Operation
- Storage: DEPTH x 8 array, write pointer, read pointer (log2 DEPTH bits, natural wrap), count register CW bits.
- Write is accepted when i_Wr_En && (!o_Full || pop this cycle). On accept, mem[wptr] <= i_Wr_Byte and wptr increments. A write while full with no pop is dropped, o_Overflow <= 1, and FIFO is unchanged.
- o_Overflow is cleared by i_Clr_Ovf. If set and clear occur in the same cycle, set wins.
- Count update: +1 on accepted write only, -1 on pop only, unchanged when both or neither.
- Launcher FSM, all outputs registered:
  - L_IDLE: if i_Tx_Enable && !o_Empty, pop: o_Tx_Byte <= mem[rptr], rptr++, o_Tx_DV <= 1, go to L_LAUNCH. Otherwise stay.
  - L_LAUNCH (1 cycle): o_Tx_DV <= 0, go to L_WAIT_DONE.
  - L_WAIT_DONE: wait for i_Tx_Done == 1, then go to L_WAIT_IDLE.
  - L_WAIT_IDLE: wait for i_Tx_Done == 0, since the transmitter holds done for 2 cycles (last stop cycle + cleanup). Then go to L_IDLE.
- o_Tx_Byte is held constant from the pop until the next pop.
- o_Tx_DV is high for exactly one cycle per byte.
- Deasserting i_Tx_Enable mid-frame does not abort; the current byte completes and no further pop occurs.
- Simultaneous write and pop on an empty FIFO is impossible, because pop requires !o_Empty sampled before the write lands.
- i_Tx_Active is unused by the FSM; it only ORs into o_Busy.

## Timing
- Reset (synchronous, on the edge with rst=1):
  - FSM -> L_IDLE
  - pointers = 0, o_Count = 0, o_Empty = 1, o_Full = 0
  - o_Overflow = 0, o_Tx_DV = 0, o_Tx_Byte = 8'h00, o_Busy = 0
  - Memory contents are not reset.
- Reset mid-frame discards queue and launcher state. The transmitter shares rst and also returns to idle.
- Write-to-launch latency with FIFO empty, launcher idle and enabled:
  - i_Wr_En in cycle N
  - o_Count = 1 in N+1 (pop decided in N+1)
  - o_Tx_DV = 1 and o_Tx_Byte valid in N+2
  - o_Count = 0 in N+2
- Back-to-back bytes: the next o_Tx_DV occurs 1 cycle after i_Tx_Done falls and the FSM re-enters L_IDLE. The inter-frame gap is bounded by that plus the transmitter's idle cycle.
- o_Full, o_Empty and o_Busy are combinational from registered state and reflect the same cycle as o_Count.

## Test plan
- Reset, then one write 8'hA5 with enable=1 -> o_Tx_DV high for exactly 1 cycle at N+2 with o_Tx_Byte=8'hA5. The transmitter model emits a 10-bit frame (0, 1010 0101 LSB-first, 1). o_Busy falls after done clears.
- Enable=0, write 16 bytes 8'h00..8'h0F, then a 17th 8'hFF -> o_Full=1, o_Count=16, o_Overflow=1, 8'hFF absent. Then enable=1 -> 16 frames in order 00..0F, no DV while i_Tx_Done high.
- FIFO full, write issued in the same cycle the launcher pops -> write accepted, o_Count stays 16, o_Overflow stays 0.
- i_Clr_Ovf and an overflowing write in the same cycle -> o_Overflow=1. A later clear alone -> 0.
- Enable dropped during the 2nd of 4 queued frames -> the 2nd frame completes, o_Count=2, no further DV until re-enabled.
- rst asserted mid-frame with 3 bytes queued -> next cycle o_Count=0, o_Tx_DV=0, FSM idle. A new write then transmits normally.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Purpose  : Bus-side write port and transmitter handshake of uart_tx_fifo.
// Revision : 1.0  initial release
// ============================================================================
interface uart_tx_fifo_if #(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          i_Wr_En;
   logic [7:0]    i_Wr_Byte;
   logic          i_Tx_Enable;
   logic          i_Clr_Ovf;
   logic          o_Full;
   logic          o_Empty;
   logic [CW-1:0] o_Count;
   logic          o_Overflow;
   logic          o_Busy;
   logic          o_Tx_DV;
   logic [7:0]    o_Tx_Byte;
   logic          i_Tx_Active;
   logic          i_Tx_Done;

   // master drives the bus/transmitter side, slave is the FIFO itself
   modport master (
      output i_Wr_En, i_Wr_Byte, i_Tx_Enable, i_Clr_Ovf, i_Tx_Active, i_Tx_Done,
      input  o_Full, o_Empty, o_Count, o_Overflow, o_Busy, o_Tx_DV, o_Tx_Byte
   );

   modport slave (
      input  i_Wr_En, i_Wr_Byte, i_Tx_Enable, i_Clr_Ovf, i_Tx_Active, i_Tx_Done,
      output o_Full, o_Empty, o_Count, o_Overflow, o_Busy, o_Tx_DV, o_Tx_Byte
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : DEPTH-entry byte FIFO feeding a UART transmitter one byte at a time.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int DEPTH = 16
) (
   input wire            i_Clock,
   input wire            rst,
   uart_tx_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] c_FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] c_CNT_ONE    = CW'(1);
   localparam logic [AW-1:0] c_PTR_ONE    = AW'(1);

   typedef enum logic [1:0] {
      L_IDLE      = 2'd0,
      L_LAUNCH    = 2'd1,
      L_WAIT_DONE = 2'd2,
      L_WAIT_IDLE = 2'd3
   } launch_state_t;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic          r_tx_dv;
   logic [7:0]    r_tx_byte;
   launch_state_t r_state;

   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_wr_accept;
   logic w_wr_drop;

   assign w_full      = (r_count == c_FULL_COUNT);
   assign w_empty     = (r_count == '0);
   assign w_pop       = (r_state == L_IDLE) && bus.i_Tx_Enable && !w_empty;
   // a pop frees a slot in the same cycle, so a full FIFO can still take a write
   assign w_wr_accept = bus.i_Wr_En && (!w_full || w_pop);
   assign w_wr_drop   = bus.i_Wr_En && !w_wr_accept;

   always_ff @(posedge i_Clock) begin
      if (w_wr_accept) begin
         r_mem[r_wptr] <= bus.i_Wr_Byte;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr_accept) begin
            r_wptr <= r_wptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_PTR_ONE;
         end
         if (w_wr_accept && !w_pop) begin
            r_count <= r_count + c_CNT_ONE;
         end else if (w_pop && !w_wr_accept) begin
            r_count <= r_count - c_CNT_ONE;
         end
      end
   end

   always_ff @(posedge i_Clock) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_wr_drop) begin
         r_overflow <= 1'b1;
      end else if (bus.i_Clr_Ovf) begin
         r_overflow <= 1'b0;
      end
   end

   // done is held for two cycles by the transmitter, so wait for its release
   always_ff @(posedge i_Clock) begin
      if (rst) begin
         r_state   <= L_IDLE;
         r_tx_dv   <= 1'b0;
         r_tx_byte <= 8'h00;
      end else begin
         case (r_state)
            L_IDLE: begin
               if (w_pop) begin
                  r_tx_byte <= r_mem[r_rptr];
                  r_tx_dv   <= 1'b1;
                  r_state   <= L_LAUNCH;
               end
            end
            L_LAUNCH: begin
               r_tx_dv <= 1'b0;
               r_state <= L_WAIT_DONE;
            end
            L_WAIT_DONE: begin
               if (bus.i_Tx_Done) begin
                  r_state <= L_WAIT_IDLE;
               end
            end
            L_WAIT_IDLE: begin
               if (!bus.i_Tx_Done) begin
                  r_state <= L_IDLE;
               end
            end
            default: begin
               r_tx_dv <= 1'b0;
               r_state <= L_IDLE;
            end
         endcase
      end
   end

   assign bus.o_Full     = w_full;
   assign bus.o_Empty    = w_empty;
   assign bus.o_Count    = r_count;
   assign bus.o_Overflow = r_overflow;
   assign bus.o_Busy     = !w_empty || (r_state != L_IDLE) || bus.i_Tx_Active;
   assign bus.o_Tx_DV    = r_tx_dv;
   assign bus.o_Tx_Byte  = r_tx_byte;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Queue-based reference model, transmitter model and directed/random stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;
   localparam int DEPTH = 16;

   logic i_Clock = 1'b0;
   logic rst     = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();
   uart_tx_fifo #(.DEPTH(DEPTH)) dut (.i_Clock(i_Clock), .rst(rst), .bus(bus));

   always #5 i_Clock = ~i_Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: a byte queue plus one in-flight byte
   logic [7:0] m_q[$];
   bit         m_valid = 1'b0;
   bit         m_inflight = 1'b0;
   bit         m_launched = 1'b0;
   bit         m_done_seen = 1'b0;
   bit         m_dv = 1'b0;
   bit         m_ovf = 1'b0;
   logic [7:0] m_byte = 8'h00;

   initial forever begin : p_model
      bit pop;
      bit acc;
      @(posedge i_Clock);
      if (rst) begin
         m_q.delete();
         m_inflight = 1'b0;
         m_dv       = 1'b0;
         m_byte     = 8'h00;
         m_ovf      = 1'b0;
         m_valid    = 1'b1;
      end else begin
         pop = !m_inflight && bus.i_Tx_Enable && (m_q.size() != 0);
         acc = bus.i_Wr_En && ((m_q.size() < DEPTH) || pop);
         m_dv = pop;
         if (pop) m_byte = m_q.pop_front();
         if (acc) m_q.push_back(bus.i_Wr_Byte);
         if (bus.i_Wr_En && !acc) m_ovf = 1'b1;
         else if (bus.i_Clr_Ovf) m_ovf = 1'b0;
         // the launcher is free again the cycle after done drops
         if (m_inflight) begin
            if (!m_launched) m_launched = 1'b1;
            else if (!m_done_seen) m_done_seen = bus.i_Tx_Done;
            else if (!bus.i_Tx_Done) m_inflight = 1'b0;
         end else if (pop) begin
            m_inflight  = 1'b1;
            m_launched  = 1'b0;
            m_done_seen = 1'b0;
         end
      end
   end

   initial forever begin : p_compare
      @(negedge i_Clock);
      #2;
      if (m_valid) begin
         check("count",    32'(bus.o_Count), 32'(m_q.size()));
         check("full",     32'(bus.o_Full), 32'(m_q.size() == DEPTH));
         check("empty",    32'(bus.o_Empty), 32'(m_q.size() == 0));
         check("overflow", 32'(bus.o_Overflow), 32'(m_ovf));
         check("busy",     32'(bus.o_Busy),
               32'((m_q.size() != 0) || m_inflight || bus.i_Tx_Active));
         check("tx_dv",    32'(bus.o_Tx_DV), 32'(m_dv));
         check("tx_byte",  32'(bus.o_Tx_Byte), 32'(m_byte));
      end
   end

   // ---------------- transmitter model: random frame length, done held 2 cycles
   int         tx_phase = 0;
   int         tx_cnt   = 0;
   logic [7:0] cap[$];

   initial begin
      bus.i_Tx_Active = 1'b0;
      bus.i_Tx_Done   = 1'b0;
      forever begin
         @(negedge i_Clock);
         if (rst) begin
            tx_phase        = 0;
            bus.i_Tx_Active = 1'b0;
            bus.i_Tx_Done   = 1'b0;
         end else begin
            if (bus.o_Tx_DV === 1'b1) check("dv_while_tx_free", 32'(tx_phase == 0), 32'd1);
            case (tx_phase)
               0: if (bus.o_Tx_DV === 1'b1) begin
                     cap.push_back(bus.o_Tx_Byte);
                     tx_phase        = 1;
                     tx_cnt          = int'($urandom_range(3, 12));
                     bus.i_Tx_Active = 1'b1;
                  end
               1: begin
                     tx_cnt--;
                     if (tx_cnt == 0) begin
                        tx_phase      = 2;
                        tx_cnt        = 2;
                        bus.i_Tx_Done = 1'b1;
                     end
                  end
               2: begin
                     tx_cnt--;
                     if (tx_cnt == 0) begin
                        tx_phase        = 3;
                        bus.i_Tx_Done   = 1'b0;
                        bus.i_Tx_Active = 1'b0;
                     end
                  end
               default: tx_phase = 0;
            endcase
         end
      end
   end

   // ---------------- stimulus helpers
   task automatic tick();
      @(negedge i_Clock);
      #1;
   endtask

   task automatic write(input logic [7:0] b);
      bus.i_Wr_En   = 1'b1;
      bus.i_Wr_Byte = b;
      tick();
      bus.i_Wr_En   = 1'b0;
   endtask

   task automatic wait_cap(input int n, input int budget);
      int k = 0;
      while (cap.size() < n && k < budget) begin
         tick();
         k++;
      end
      check("frames_seen", 32'(cap.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (bus.o_Busy !== 1'b0 && k < budget) begin
         tick();
         k++;
      end
      check("went_idle", 32'(bus.o_Busy), 32'd0);
   endtask

   function automatic logic [31:0] cap_at(input int i);
      return (i < cap.size()) ? 32'(cap[i]) : 32'hFFFF_FFFF;
   endfunction

   initial begin : p_main
      logic [9:0] frame;
      bus.i_Wr_En = 1'b0; bus.i_Wr_Byte = 8'h00;
      bus.i_Tx_Enable = 1'b0; bus.i_Clr_Ovf = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_count", 32'(bus.o_Count), 32'd0);
      check("rst_empty", 32'(bus.o_Empty), 32'd1);
      check("rst_full",  32'(bus.o_Full), 32'd0);
      check("rst_ovf",   32'(bus.o_Overflow), 32'd0);
      check("rst_dv",    32'(bus.o_Tx_DV), 32'd0);
      check("rst_byte",  32'(bus.o_Tx_Byte), 32'h00);
      check("rst_busy",  32'(bus.o_Busy), 32'd0);

      // single byte: latency N+1 count, N+2 launch
      bus.i_Tx_Enable = 1'b1;
      cap.delete();
      write(8'hA5);
      check("lat1_count", 32'(bus.o_Count), 32'd1);
      check("lat1_dv",    32'(bus.o_Tx_DV), 32'd0);
      tick();
      check("lat2_dv",    32'(bus.o_Tx_DV), 32'd1);
      check("lat2_byte",  32'(bus.o_Tx_Byte), 32'hA5);
      check("lat2_count", 32'(bus.o_Count), 32'd0);
      tick();
      check("lat3_dv",    32'(bus.o_Tx_DV), 32'd0);
      wait_cap(1, 50);
      frame = {1'b1, cap_at(0)[7:0], 1'b0};
      check("a5_frame", 32'(frame), 32'h34A);
      wait_idle(100);

      // fill to full, overflow, then drain in order
      bus.i_Tx_Enable = 1'b0;
      cap.delete();
      for (int i = 0; i < 16; i++) write(8'(i));
      write(8'hFF);
      check("fill_full",  32'(bus.o_Full), 32'd1);
      check("fill_count", 32'(bus.o_Count), 32'd16);
      check("fill_ovf",   32'(bus.o_Overflow), 32'd1);
      bus.i_Tx_Enable = 1'b1;
      wait_cap(16, 600);
      for (int i = 0; i < 16; i++) check("drain_order", cap_at(i), 32'(i));
      wait_idle(100);
      check("no_ff_frame", 32'(cap.size()), 32'd16);

      // write while full in the same cycle as a pop
      bus.i_Tx_Enable = 1'b0;
      bus.i_Clr_Ovf = 1'b1;
      tick();
      bus.i_Clr_Ovf = 1'b0;
      for (int i = 0; i < 16; i++) write(8'(8'h40 + i));
      check("refill_count", 32'(bus.o_Count), 32'd16);
      bus.i_Tx_Enable = 1'b1;
      write(8'hEE);
      bus.i_Tx_Enable = 1'b0;
      check("popwr_count", 32'(bus.o_Count), 32'd16);
      check("popwr_ovf",   32'(bus.o_Overflow), 32'd0);
      check("popwr_dv",    32'(bus.o_Tx_DV), 32'd1);
      check("popwr_byte",  32'(bus.o_Tx_Byte), 32'h40);

      // set beats clear
      bus.i_Clr_Ovf = 1'b1;
      write(8'h99);
      bus.i_Clr_Ovf = 1'b0;
      check("set_wins_ovf", 32'(bus.o_Overflow), 32'd1);
      bus.i_Clr_Ovf = 1'b1;
      tick();
      bus.i_Clr_Ovf = 1'b0;
      check("clr_ovf", 32'(bus.o_Overflow), 32'd0);

      // enable dropped during the 2nd of 4 frames
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      cap.delete();
      write(8'h11); write(8'h22); write(8'h33); write(8'h44);
      bus.i_Tx_Enable = 1'b1;
      wait_cap(2, 100);
      bus.i_Tx_Enable = 1'b0;
      check("pause_count", 32'(bus.o_Count), 32'd2);
      repeat (60) tick();
      check("pause_frames", 32'(cap.size()), 32'd2);
      check("pause_count2", 32'(bus.o_Count), 32'd2);
      bus.i_Tx_Enable = 1'b1;
      wait_cap(4, 200);
      check("resume_b2", cap_at(2), 32'h33);
      check("resume_b3", cap_at(3), 32'h44);
      wait_idle(100);

      // reset mid-frame with 3 bytes queued
      bus.i_Tx_Enable = 1'b0;
      cap.delete();
      write(8'h01); write(8'h02); write(8'h03); write(8'h04);
      bus.i_Tx_Enable = 1'b1;
      wait_cap(1, 50);
      check("mid_count", 32'(bus.o_Count), 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_count", 32'(bus.o_Count), 32'd0);
      check("mrst_dv",    32'(bus.o_Tx_DV), 32'd0);
      check("mrst_busy",  32'(bus.o_Busy), 32'd0);
      cap.delete();
      write(8'h5A);
      wait_cap(1, 50);
      check("post_rst_byte", cap_at(0), 32'h5A);
      wait_idle(100);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         bus.i_Wr_En   = ($urandom_range(0, 99) < 30);
         bus.i_Wr_Byte = 8'($urandom);
         if ($urandom_range(0, 49) == 0) bus.i_Tx_Enable = ~bus.i_Tx_Enable;
         bus.i_Clr_Ovf = ($urandom_range(0, 19) == 0);
         rst           = ($urandom_range(0, 499) == 0);
         tick();
      end
      bus.i_Wr_En = 1'b0; bus.i_Clr_Ovf = 1'b0; rst = 1'b0;
      bus.i_Tx_Enable = 1'b1;
      wait_idle(1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : p_watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
